// File: rtl/iic_pkg.sv
// Shared types and constants for the two-requester IIC arbiter.
package iic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAIL    = 3'd5
  } state_e;

  localparam int TRIG_TO_DEF = 1023;
  localparam int BUSY_TO_DEF = 4194303;
  localparam int TMR_W       = 22;

  localparam logic W_WRITE = 1'b1;
  localparam logic W_READ  = 1'b0;

endpackage

// File: rtl/iic_arb_if.sv
// Requester-side and IIC-master-side signals of the arbiter in one bundle.
interface iic_arb_if;

  // Requesters hold rq_req high until they see their done/err pulse;
  // iic_trig is a one-cycle start and busy's falling edge ends the transfer.
  logic [1:0]  rq_req;
  logic [1:0]  rq_wr;
  logic [15:0] rq_dev;
  logic [31:0] rq_addr;
  logic [15:0] rq_wdata;
  logic [1:0]  rq_done;
  logic [1:0]  rq_err;
  logic [7:0]  rq_rdata;
  logic [1:0]  rq_gnt;
  logic        iic_trig;
  logic        w_r;
  logic [7:0]  device_id;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        busy;
  logic [7:0]  data_out;

  modport master (
    input  rq_req, rq_wr, rq_dev, rq_addr, rq_wdata, busy, data_out,
    output rq_done, rq_err, rq_rdata, rq_gnt, iic_trig, w_r, device_id, addr, data_in
  );

  modport slave (
    output rq_req, rq_wr, rq_dev, rq_addr, rq_wdata, busy, data_out,
    input  rq_done, rq_err, rq_rdata, rq_gnt, iic_trig, w_r, device_id, addr, data_in
  );

endinterface

// File: rtl/iic_arb_rr_arb2.sv
// Two-way round-robin selector: on contention the requester that did not own last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/iic_arb.sv
// Shares one IIC master between two requesters; round-robin, with start and busy timeouts.
module iic_arb
  import iic_pkg::*;
#(
  parameter int TRIG_TO = TRIG_TO_DEF,
  parameter int BUSY_TO = BUSY_TO_DEF
) (
  input  logic      clk,
  input  logic      rst,
  iic_arb_if.master bus,
  output state_e    state_o
);

  localparam logic [TMR_W-1:0] TRIG_LIM = TMR_W'(TRIG_TO);
  localparam logic [TMR_W-1:0] BUSY_LIM = TMR_W'(BUSY_TO);

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             ptr_q, ptr_d;
  logic             w_r_q, w_r_d;
  logic [7:0]       dev_q, dev_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             busy_1d_q;

  logic [1:0] win_gnt;
  logic       win_idx;

  rr_arb2 u_rr (
    .req_i  (bus.rq_req),
    .last_i (ptr_q),
    .gnt_o  (win_gnt)
  );

  assign win_idx = win_gnt[1];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    w_r_d   = w_r_q;
    dev_d   = dev_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.rq_req) begin
          state_d = ST_GRANT;
          gnt_d   = win_gnt;
          w_r_d   = bus.rq_wr[win_idx];
          dev_d   = bus.rq_dev[{win_idx, 3'b000} +: 8];
          addr_d  = bus.rq_addr[{win_idx, 4'b0000} +: 16];
          wdata_d = bus.rq_wdata[{win_idx, 3'b000} +: 8];
        end
      end
      ST_GRANT:   state_d = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (bus.busy) begin
          state_d = ST_WAIT_LO;
        end else if (timer_q >= TRIG_LIM) begin
          state_d = ST_FAIL;
          ptr_d   = gnt_q[1];
        end
      end
      ST_WAIT_LO: begin
        // A falling edge on the limit cycle still counts as success.
        if (busy_1d_q && !bus.busy) begin
          state_d = ST_DONE;
          ptr_d   = gnt_q[1];
        end else if (timer_q >= BUSY_LIM) begin
          state_d = ST_FAIL;
          ptr_d   = gnt_q[1];
        end
      end
      ST_DONE: begin
        if (w_r_q == W_READ) rdata_d = bus.data_out;
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
      ST_FAIL: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end else if ((state_q == ST_WAIT_HI || state_q == ST_WAIT_LO) && timer_q != {TMR_W{1'b1}}) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 2'b00;
      ptr_q     <= 1'b1;
      w_r_q     <= W_WRITE;
      dev_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      timer_q   <= '0;
      busy_1d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      w_r_q     <= w_r_d;
      dev_q     <= dev_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      timer_q   <= timer_d;
      busy_1d_q <= bus.busy;
    end
  end

  assign bus.iic_trig  = (state_q == ST_GRANT);
  assign bus.rq_done   = (state_q == ST_DONE) ? gnt_q : 2'b00;
  assign bus.rq_err    = (state_q == ST_FAIL) ? gnt_q : 2'b00;
  assign bus.rq_gnt    = gnt_q;
  assign bus.rq_rdata  = rdata_q;
  assign bus.w_r       = w_r_q;
  assign bus.device_id = dev_q;
  assign bus.addr      = addr_q;
  assign bus.data_in   = wdata_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_iic_arb.sv
// Randomised bench for iic_arb with a transaction-level reference model and a simple IIC master model.
module tb_iic_arb;
  import iic_pkg::*;

  localparam int TRIG_TO = 20;
  localparam int BUSY_TO = 60;

  logic   clk = 1'b0;
  logic   rst;
  state_e state;
  int     checks = 0;
  int     errors = 0;

  // reference model: last owner and last read byte
  int         last_own;
  logic [7:0] exp_rdata;
  logic [1:0] exp_q[$];

  iic_arb_if bus();

  iic_arb #(.TRIG_TO(TRIG_TO), .BUSY_TO(BUSY_TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.master),
    .state_o (state)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.rq_req   = 2'b00;
    bus.rq_wr    = 2'b00;
    bus.rq_dev   = '0;
    bus.rq_addr  = '0;
    bus.rq_wdata = '0;
    bus.busy     = 1'b0;
    bus.data_out = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    rst       = 1'b0;
    last_own  = 1;
    exp_rdata = 8'h00;
  endtask

  task automatic rand_fields();
    bus.rq_wr    = 2'($urandom_range(0, 3));
    bus.rq_dev   = 16'($urandom);
    bus.rq_addr  = $urandom;
    bus.rq_wdata = 16'($urandom);
  endtask

  // One arbitrated transaction, called on a negedge while the arbiter is idle.
  // Cycle c counts negedges after the iic_trig cycle (c = 0).
  task automatic txn(input int rise_dly, input int busy_len, input bit never_rise,
                     input int drop_at, input logic [7:0] rd_byte, output logic [1:0] got_gnt);
    int          own;
    int          end_c;
    bit          exp_err;
    bit          seen;
    logic        wr;
    logic [1:0]  exp_g;
    logic [3:0]  exp_de;
    logic [32:0] exp_f;
    logic [32:0] got_f;
    logic [1:0]  req;

    req = bus.rq_req;
    if (req == 2'b01)      own = 0;
    else if (req == 2'b10) own = 1;
    else                   own = (last_own == 0) ? 1 : 0;
    exp_g = (own == 0) ? 2'b01 : 2'b10;
    wr    = bus.rq_wr[own];
    exp_f = {bus.rq_wr[own], bus.rq_dev[own*8 +: 8], bus.rq_addr[own*16 +: 16], bus.rq_wdata[own*8 +: 8]};

    if (never_rise) begin
      end_c   = TRIG_TO + 2;
      exp_err = 1'b1;
    end else if (busy_len <= BUSY_TO + 1) begin
      end_c   = rise_dly + busy_len + 1;
      exp_err = 1'b0;
    end else begin
      end_c   = rise_dly + BUSY_TO + 2;
      exp_err = 1'b1;
    end
    exp_de = exp_err ? {2'b00, exp_g} : {exp_g, 2'b00};

    @(negedge clk);
    got_gnt = bus.rq_gnt;
    checks++;
    if (bus.iic_trig !== 1'b1) begin
      errors++;
      $display("FAIL trig_latency: got iic_trig=%b expected 1", bus.iic_trig);
    end
    checks++;
    if (bus.rq_gnt !== exp_g) begin
      errors++;
      $display("FAIL grant: got %b expected %b", bus.rq_gnt, exp_g);
    end
    got_f = {bus.w_r, bus.device_id, bus.addr, bus.data_in};
    checks++;
    if (got_f !== exp_f) begin
      errors++;
      $display("FAIL master_fields: got %h expected %h", got_f, exp_f);
    end

    seen = 1'b0;
    for (int c = 1; c <= end_c + 5 && !seen; c++) begin
      @(negedge clk);
      if (bus.rq_done !== 2'b00 || bus.rq_err !== 2'b00) begin
        seen = 1'b1;
        checks++;
        if (c != end_c) begin
          errors++;
          $display("FAIL end_cycle: got %0d expected %0d", c, end_c);
        end
        checks++;
        if ({bus.rq_done, bus.rq_err} !== exp_de) begin
          errors++;
          $display("FAIL done_err: got %b expected %b", {bus.rq_done, bus.rq_err}, exp_de);
        end
        checks++;
        if (bus.rq_gnt !== exp_g) begin
          errors++;
          $display("FAIL owner_held: got %b expected %b", bus.rq_gnt, exp_g);
        end
      end else begin
        if (!never_rise && c == rise_dly) begin
          bus.busy     = 1'b1;
          bus.data_out = 8'($urandom);
        end
        if (!never_rise && c == rise_dly + busy_len) begin
          bus.busy     = 1'b0;
          bus.data_out = rd_byte;
        end
        if (c == drop_at) bus.rq_req = 2'b00;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL completion_timeout: got none expected pulse at cycle %0d", end_c);
    end
    bus.busy = 1'b0;

    last_own = own;
    if (!exp_err && wr == W_READ) exp_rdata = rd_byte;

    @(negedge clk);
    checks++;
    if ({bus.rq_gnt, bus.rq_done, bus.rq_err, bus.iic_trig, bus.rq_rdata} !== {7'b0, exp_rdata}) begin
      errors++;
      $display("FAIL after_txn: got gnt=%b done=%b err=%b trig=%b rdata=%h expected 0/0/0/0/%h",
               bus.rq_gnt, bus.rq_done, bus.rq_err, bus.iic_trig, bus.rq_rdata, exp_rdata);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (state !== ST_IDLE || {bus.rq_gnt, bus.iic_trig, bus.rq_done, bus.rq_err} !== 7'b0 ||
        bus.w_r !== 1'b1 || {bus.device_id, bus.addr, bus.data_in, bus.rq_rdata} !== 40'h0) begin
      errors++;
      $display("FAIL %s: got st=%0d gnt=%b trig=%b done=%b err=%b w_r=%b dev=%h addr=%h din=%h rdata=%h expected idle/0/0/0/0/1/0/0/0/0",
               name, state, bus.rq_gnt, bus.iic_trig, bus.rq_done, bus.rq_err, bus.w_r,
               bus.device_id, bus.addr, bus.data_in, bus.rq_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_values");
    rst       = 1'b0;
    last_own  = 1;
    exp_rdata = 8'h00;
    @(negedge clk);
    checks++;
    if (bus.rq_gnt !== 2'b00 || bus.iic_trig !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got gnt=%b trig=%b expected 00/0", bus.rq_gnt, bus.iic_trig);
    end
  endtask

  task automatic test_directed_write();
    logic [1:0] g;
    apply_reset();
    bus.rq_wr    = 2'b01;
    bus.rq_dev   = 16'h00B2;
    bus.rq_addr  = 32'h0000_0003;
    bus.rq_wdata = 16'h005A;
    bus.rq_req   = 2'b01;
    txn(1, 40, 1'b0, -1, 8'h00, g);
    bus.rq_req = 2'b00;
    checks++;
    if (g !== 2'b01) begin
      errors++;
      $display("FAIL directed_write_gnt: got %b expected 01", g);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    logic [1:0] e;
    apply_reset();
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    bus.rq_req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      txn($urandom_range(1, 4), $urandom_range(1, 20), 1'b0, -1, 8'($urandom), g);
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL round_robin_%0d: got %b expected %b", i, g, e);
      end
    end
    bus.rq_req = 2'b00;
  endtask

  task automatic test_read();
    logic [1:0] g;
    bus.rq_wr    = 2'b01;
    bus.rq_dev   = 16'h4400;
    bus.rq_addr  = 32'h0003_0000;
    bus.rq_req   = 2'b10;
    txn(2, 10, 1'b0, -1, 8'h5A, g);
    bus.rq_req = 2'b00;
    checks++;
    if (bus.rq_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL read_data: got %h expected 5a", bus.rq_rdata);
    end
  endtask

  task automatic test_trig_timeout();
    logic [1:0] g;
    rand_fields();
    bus.rq_req = 2'b10;
    txn(1, 1, 1'b1, -1, 8'h00, g);
    rand_fields();
    bus.rq_req = 2'b01;
    txn(3, 7, 1'b0, -1, 8'($urandom), g);
    bus.rq_req = 2'b00;
  endtask

  task automatic test_busy_timeout();
    logic [1:0] g;
    rand_fields();
    bus.rq_req = 2'b01;
    txn(2, BUSY_TO + 10, 1'b0, -1, 8'h00, g);
    bus.rq_req = 2'b00;
  endtask

  task automatic test_drop_req();
    logic [1:0] g;
    rand_fields();
    bus.rq_req = 2'b01;
    txn(1, 15, 1'b0, 3, 8'($urandom), g);
    bus.rq_req = 2'b00;
  endtask

  task automatic test_reset_mid();
    bit pulsed;
    rand_fields();
    bus.rq_req = 2'b01;
    @(negedge clk);
    @(negedge clk);
    bus.busy = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== ST_WAIT_LO) begin
      errors++;
      $display("FAIL reach_wait_lo: got state %0d expected %0d", state, ST_WAIT_LO);
    end
    rst        = 1'b1;
    bus.rq_req = 2'b00;
    @(negedge clk);
    check_reset_outputs("reset_mid_txn");
    rst       = 1'b0;
    last_own  = 1;
    exp_rdata = 8'h00;
    @(negedge clk);
    bus.busy = 1'b0;
    pulsed   = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rq_done !== 2'b00 || bus.rq_err !== 2'b00) pulsed = 1'b1;
    end
    checks++;
    if (pulsed) begin
      errors++;
      $display("FAIL no_pulse_after_reset: got pulse expected none");
    end
  endtask

  task automatic test_random();
    logic [1:0] g;
    int         len;
    for (int i = 0; i < 25; i++) begin
      rand_fields();
      bus.rq_req = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) len = BUSY_TO + $urandom_range(0, 3);
      else                           len = $urandom_range(1, 30);
      txn($urandom_range(1, 4), len, ($urandom_range(0, 9) == 0), -1, 8'($urandom), g);
    end
    bus.rq_req = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_directed_write();
    test_round_robin();
    test_read();
    test_trig_timeout();
    test_busy_timeout();
    test_drop_req();
    test_read();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iic_arb.md
IIC_ARB -- requirements
Module: iic_arb

Interface
REQ-001 Parameter TRIG_TO, default 1023: maximum cycles from iic_trig until busy is sampled high.
REQ-002 Parameter BUSY_TO, default 4194303: maximum cycles busy may stay high in one transaction.
REQ-003 clk  in  1  single clock; all logic is on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rq_req  in  2  per-requester transaction request, level; bit0 = requester 0.
REQ-006 rq_wr  in  2  per-requester direction; 1 = write, 0 = read.
REQ-007 rq_dev  in  16  per-requester 8-bit device_id, packed {r1,r0}.
REQ-008 rq_addr  in  32  per-requester 16-bit register address, packed {r1,r0}.
REQ-009 rq_wdata  in  16  per-requester 8-bit write data, packed {r1,r0}.
REQ-010 rq_done  out  2  one-cycle pulse to the owning requester on successful completion.
REQ-011 rq_err  out  2  one-cycle pulse to the owning requester on timeout.
REQ-012 rq_rdata  out  8  read data from the last completed transaction, shared by both requesters.
REQ-013 rq_gnt  out  2  one-hot current owner, or 0 when idle.
REQ-014 iic_trig  out  1  one-cycle start pulse to the IIC master.
REQ-015 w_r  out  1  direction to the master; 1 = write.
REQ-016 device_id  out  8  slave ID to the master.
REQ-017 addr  out  16  register address to the master.
REQ-018 data_in  out  8  write byte to the master.
REQ-019 busy  in  1  master busy; the falling edge marks the end of a transaction.
REQ-020 data_out  in  8  master read byte; valid at the busy falling edge.

Function
REQ-021 FSM states and transitions:
- IDLE -> GRANT when rq_req != 0.
- GRANT -> WAIT_HI.
- WAIT_HI -> WAIT_LO when busy = 1; WAIT_HI -> FAIL when the timer reaches TRIG_TO.
- WAIT_LO -> DONE on busy falling (busy_1d & ~busy); WAIT_LO -> FAIL when the timer reaches BUSY_TO.
- DONE -> IDLE; FAIL -> IDLE.
REQ-022 IDLE, one cycle, on any request:
- registers the winner into rq_gnt;
- registers the winner's fields into w_r, device_id, addr and data_in.
REQ-023 iic_trig SHALL be 1 for exactly the GRANT cycle, which is the cycle after the request was sampled in IDLE; the master fields are already stable in that cycle.
REQ-024 Arbitration is round-robin with a one-bit last-owner pointer:
- single request: that requester wins;
- both requesting: the requester that is not the last owner wins;
- the pointer updates on entry to DONE or FAIL.
REQ-025 Requests arriving while not in IDLE are held pending; rq_req dropping mid-transaction does not abort it, and done/err still pulses.
REQ-026 In DONE:
- rq_rdata <= data_out if w_r = 0, otherwise unchanged;
- rq_done[owner] = 1 for one cycle.
REQ-027 In FAIL, rq_err[owner] = 1 for one cycle and rq_rdata is unchanged.
REQ-028 rq_gnt clears on return to IDLE.
REQ-029 Master fields hold their values until the next grant.
REQ-030 Timeout timer:
- 22 bits;
- cleared on every state change;
- increments in WAIT_HI and WAIT_LO;
- saturates, never wraps.
REQ-031 Minimum back-to-back spacing: after DONE, IDLE lasts at least one cycle before the next GRANT.
REQ-032 rq_done and rq_err are never both asserted, and never asserted for a non-owner.

Reset
REQ-033 While rst = 1 at a clock edge:
- state = IDLE;
- rq_gnt = 0, iic_trig = 0, rq_done = 0, rq_err = 0;
- w_r = 1;
- device_id = 0, addr = 0, data_in = 0, rq_rdata = 0;
- pointer = 1, so requester 0 wins first;
- busy_1d = 0, timer = 0.
REQ-034 rst asserted mid-transaction aborts it with no done/err pulse; the master is not notified.

Structure
REQ-035 Shared package iic_pkg holds:
- the FSM state encoding;
- the default TRIG_TO and BUSY_TO constants;
- W_WRITE = 1 and W_READ = 0.
REQ-036 The round-robin selector is a sub-module, rr_arb2 (2 requests, pointer in, one-hot grant out); all other logic is flat.

Verification
REQ-037 After reset, rq_req = 01 with dev B2, addr 0003, wdata 5A, wr = 1:
- iic_trig pulses 1 cycle after the request;
- the model raises busy for 40 cycles;
- rq_done = 01 pulses 1 cycle after the busy falling edge is detected.
REQ-038 rq_req = 11 is held for 3 transactions: grants go 01, 10, 01.
REQ-039 Read from requester 1 at addr 0003, model returns data_out = 5A: rq_rdata = 5A in the cycle after rq_done = 10.
REQ-040 Busy never rises: rq_err[owner] pulses after TRIG_TO + 1 WAIT_HI cycles, then the FSM returns to IDLE and serves the next request normally.
REQ-041 rst asserted in WAIT_LO:
- next cycle all outputs are at reset values;
- no rq_done pulse.
REQ-042 Requester 0 drops rq_req during WAIT_LO: the transaction completes and rq_done = 01 still pulses.
